// File: rtl/vx_mem_responder.sv
// vx_mem_responder: on-chip memory endpoint for the Vortex mem_req/mem_rsp interface.
// Optional feature macro: VX_MEM_RSP_RANDOM_STALL_EN (LFSR-driven ready/valid stalls).
module vx_mem_responder #(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 26,
  parameter int TAG_WIDTH  = 8,
  parameter int MEM_DEPTH  = 1024,
  parameter int LATENCY    = 4,
  parameter int QUEUE_SIZE = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mem_req_valid,
  input  logic                    mem_req_rw,
  input  logic [DATA_WIDTH/8-1:0] mem_req_byteen,
  input  logic [ADDR_WIDTH-1:0]   mem_req_addr,
  input  logic [DATA_WIDTH-1:0]   mem_req_data,
  input  logic [TAG_WIDTH-1:0]    mem_req_tag,
  output logic                    mem_req_ready,
  output logic                    mem_rsp_valid,
  output logic [DATA_WIDTH-1:0]   mem_rsp_data,
  output logic [TAG_WIDTH-1:0]    mem_rsp_tag,
  input  logic                    mem_rsp_ready
);
  localparam int BYTES  = DATA_WIDTH / 8;
  localparam int IDX_W  = $clog2(MEM_DEPTH);
  localparam int QPTR_W = $clog2(QUEUE_SIZE);
  localparam int CNT_W  = QPTR_W + 1;

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  logic [LATENCY-1:0]    pipe_valid_q;
  logic [DATA_WIDTH-1:0] pipe_data_q [LATENCY];
  logic [TAG_WIDTH-1:0]  pipe_tag_q  [LATENCY];

  logic [DATA_WIDTH-1:0] fifo_data_q [QUEUE_SIZE];
  logic [TAG_WIDTH-1:0]  fifo_tag_q  [QUEUE_SIZE];
  logic [QPTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [CNT_W-1:0]      pending_q, pending_d;

  logic [IDX_W-1:0] idx_s;
  logic req_ready_s, rsp_valid_s;
  logic req_fire_s, wr_fire_s, rd_fire_s;
  logic push_s, pop_s;
  logic req_stall_s, rsp_stall_s;
  logic unused_addr_s;

  assign idx_s         = mem_req_addr[IDX_W-1:0];
  assign unused_addr_s = ^mem_req_addr[ADDR_WIDTH-1:IDX_W];

`ifdef VX_MEM_RSP_RANDOM_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Fibonacci LFSR, taps 16,14,13,11.
  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  // LFSR state register, reseeded on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign req_stall_s = (lfsr_q[1:0] == 2'b00);
  assign rsp_stall_s = (lfsr_q[3:2] == 2'b00);
`else
  assign req_stall_s = 1'b0;
  assign rsp_stall_s = 1'b0;
`endif

  // Credit bounds pipeline + FIFO occupancy, so the FIFO never needs to push back.
  assign req_ready_s = !reset && (pending_q < CNT_W'(QUEUE_SIZE)) && !req_stall_s;
  assign rsp_valid_s = (count_q != CNT_W'(0)) && !rsp_stall_s;

  assign req_fire_s = mem_req_valid && req_ready_s;
  assign wr_fire_s  = req_fire_s && mem_req_rw;
  assign rd_fire_s  = req_fire_s && !mem_req_rw;
  assign push_s     = pipe_valid_q[LATENCY-1];
  assign pop_s      = rsp_valid_s && mem_rsp_ready;

  assign mem_req_ready = req_ready_s;
  assign mem_rsp_valid = rsp_valid_s;
  assign mem_rsp_data  = (count_q != CNT_W'(0)) ? fifo_data_q[rd_ptr_q] : {DATA_WIDTH{1'b0}};
  assign mem_rsp_tag   = (count_q != CNT_W'(0)) ? fifo_tag_q[rd_ptr_q]  : {TAG_WIDTH{1'b0}};

  // Next-state for the credit and FIFO occupancy counters.
  always_comb begin
    pending_d = pending_q;
    count_d   = count_q;
    if (rd_fire_s && !pop_s) begin
      pending_d = pending_q + CNT_W'(1);
    end else if (!rd_fire_s && pop_s) begin
      pending_d = pending_q - CNT_W'(1);
    end else begin
      pending_d = pending_q;
    end
    if (push_s && !pop_s) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push_s && pop_s) begin
      count_d = count_q - CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Byte-enabled line storage; intentionally not cleared by reset.
  always_ff @(posedge clk) begin
    if (wr_fire_s) begin
      for (int b = 0; b < BYTES; b++) begin
        if (mem_req_byteen[b]) begin
          mem_q[idx_s][b*8 +: 8] <= mem_req_data[b*8 +: 8];
        end
      end
    end
  end

  // Fixed-latency read pipeline valid bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_valid_q <= '0;
    end else begin
      pipe_valid_q[0] <= rd_fire_s;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_valid_q[i] <= pipe_valid_q[i-1];
      end
    end
  end

  // Read pipeline payload; only meaningful where the matching valid bit is set.
  always_ff @(posedge clk) begin
    pipe_data_q[0] <= mem_q[idx_s];
    pipe_tag_q[0]  <= mem_req_tag;
    for (int i = 1; i < LATENCY; i++) begin
      pipe_data_q[i] <= pipe_data_q[i-1];
      pipe_tag_q[i]  <= pipe_tag_q[i-1];
    end
  end

  // Response FIFO payload, written at the tail as reads leave the pipeline.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_data_q[wr_ptr_q] <= pipe_data_q[LATENCY-1];
      fifo_tag_q[wr_ptr_q]  <= pipe_tag_q[LATENCY-1];
    end
  end

  // FIFO pointers and counters; pointers wrap naturally at a power-of-two size.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      pending_q <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_q <= wr_ptr_q + QPTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + QPTR_W'(1);
      end
      count_q   <= count_d;
      pending_q <= pending_d;
    end
  end

  vx_mem_responder_chk #(
    .QUEUE_SIZE (QUEUE_SIZE),
    .CNT_W      (CNT_W)
  ) u_chk (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .count_i (count_q)
  );

endmodule

// Guards the response FIFO against overflow and underflow.
module vx_mem_responder_chk #(
  parameter int QUEUE_SIZE = 8,
  parameter int CNT_W      = 4
) (
  input logic             clk,
  input logic             reset,
  input logic             push_i,
  input logic             pop_i,
  input logic [CNT_W-1:0] count_i
);
  // FIFO occupancy sanity checks outside reset.
  always @(posedge clk) begin
    if (!reset) begin
      assert (!(push_i && !pop_i && (count_i == CNT_W'(QUEUE_SIZE))));
      assert (!(pop_i && (count_i == CNT_W'(0))));
    end
  end
endmodule

// File: tb/tb_vx_mem_responder.sv
// Self-checking bench for vx_mem_responder: directed steps plus a randomized
// phase checked against a line-level memory model and an expected-response queue.
module tb_vx_mem_responder;
  localparam int DW    = 512;
  localparam int AW    = 26;
  localparam int TW    = 8;
  localparam int DEPTH = 1024;
  localparam int LAT   = 4;
  localparam int QS    = 8;
  localparam int BYTES = DW / 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             mem_req_valid;
  logic             mem_req_rw;
  logic [BYTES-1:0] mem_req_byteen;
  logic [AW-1:0]    mem_req_addr;
  logic [DW-1:0]    mem_req_data;
  logic [TW-1:0]    mem_req_tag;
  logic             mem_req_ready;
  logic             mem_rsp_valid;
  logic [DW-1:0]    mem_rsp_data;
  logic [TW-1:0]    mem_rsp_tag;
  logic             mem_rsp_ready;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] model_mem [int];
  logic [DW-1:0] exp_data_q [$];
  logic [TW-1:0] exp_tag_q  [$];

  vx_mem_responder #(
    .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .TAG_WIDTH (TW),
    .MEM_DEPTH (DEPTH), .LATENCY (LAT), .QUEUE_SIZE (QS)
  ) dut (
    .clk (clk), .reset (reset),
    .mem_req_valid (mem_req_valid), .mem_req_rw (mem_req_rw),
    .mem_req_byteen (mem_req_byteen), .mem_req_addr (mem_req_addr),
    .mem_req_data (mem_req_data), .mem_req_tag (mem_req_tag),
    .mem_req_ready (mem_req_ready),
    .mem_rsp_valid (mem_rsp_valid), .mem_rsp_data (mem_rsp_data),
    .mem_rsp_tag (mem_rsp_tag), .mem_rsp_ready (mem_rsp_ready)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  // Model: a request that fired updates storage (write) or queues its expected response (read).
  task automatic model_fire(input logic rw, input logic [AW-1:0] addr,
                            input logic [BYTES-1:0] be, input logic [DW-1:0] data,
                            input logic [TW-1:0] tag);
    int idx;
    logic [DW-1:0] line;
    idx = int'(addr) % DEPTH;
    line = model_mem.exists(idx) ? model_mem[idx] : '0;
    if (rw) begin
      for (int b = 0; b < BYTES; b++) if (be[b]) line[b*8 +: 8] = data[b*8 +: 8];
      model_mem[idx] = line;
    end else begin
      exp_data_q.push_back(line);
      exp_tag_q.push_back(tag);
    end
  endtask

  task automatic req(input logic rw, input logic [AW-1:0] addr, input logic [BYTES-1:0] be,
                     input logic [DW-1:0] data, input logic [TW-1:0] tag);
    mem_req_valid = 1'b1; mem_req_rw = rw; mem_req_addr = addr;
    mem_req_byteen = be; mem_req_data = data; mem_req_tag = tag;
    for (int w = 0; w < 200; w++) begin
      if (mem_req_ready) break;
      step();
    end
    chk("req_accept", mem_req_ready, 1);
    model_fire(rw, addr, be, data, tag);
    step();
    mem_req_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    for (int w = 0; w < 200; w++) begin
      if (mem_rsp_valid) break;
      step();
    end
    chk(name, mem_rsp_valid, 1);
  endtask

  task automatic get_rsp(input string name);
    wait_valid({name, "_valid"});
    if (exp_data_q.size() == 0) begin
      chk({name, "_unexpected"}, mem_rsp_valid, 0);
    end else begin
      chk({name, "_data"}, mem_rsp_data, exp_data_q.pop_front());
      chk({name, "_tag"}, mem_rsp_tag, exp_tag_q.pop_front());
    end
    mem_rsp_ready = 1'b1;
    step();
    mem_rsp_ready = 1'b0;
  endtask

  initial begin
    int n, seen, ops, cyc;
    logic [DW-1:0] wd, d1, exp2, prev_data;
    logic [TW-1:0] prev_tag;
    bit prev_hold, fired;

    reset = 1'b1; mem_req_valid = 1'b0; mem_req_rw = 1'b0; mem_req_byteen = '0;
    mem_req_addr = '0; mem_req_data = '0; mem_req_tag = '0; mem_rsp_ready = 1'b0;

    // Reset values.
    step(); step(); step();
    chk("rst_req_ready", mem_req_ready, 0);
    chk("rst_rsp_valid", mem_rsp_valid, 0);
    chk("rst_rsp_data", mem_rsp_data, 0);
    chk("rst_rsp_tag", mem_rsp_tag, 0);
    reset = 1'b0;
    #1;
    chk("post_rst_req_ready", mem_req_ready, 1);
    chk("post_rst_rsp_valid", mem_rsp_valid, 0);
    chk("post_rst_rsp_data", mem_rsp_data, 0);
    chk("post_rst_rsp_tag", mem_rsp_tag, 0);

    // Full write then read with latency measurement.
    req(1'b1, 26'h10, {BYTES{1'b1}}, {BYTES{8'hA5}}, 8'h0);
    req(1'b0, 26'h10, '0, '0, 8'h3);
    n = 0;
    while (!mem_rsp_valid && n < 50) begin step(); n++; end
    chk("rd_latency_edges", n, LAT);
    chk("t1_data_a5", mem_rsp_data, {BYTES{8'hA5}});
    get_rsp("t1");

    // Partial write: only byte 0 enabled.
    wd = rand_line(); wd[7:0] = 8'h11;
    req(1'b1, 26'h10, {{(BYTES-1){1'b0}}, 1'b1}, wd, 8'h0);
    req(1'b0, 26'h10, '0, '0, 8'h5);
    wait_valid("t2_valid_pre");
    exp2 = {BYTES{8'hA5}}; exp2[7:0] = 8'h11;
    chk("t2_byteen_line", mem_rsp_data, exp2);
    get_rsp("t2");

    // Fill credit with 8 reads under stall, then drain in order.
    for (int i = 0; i < 8; i++) req(1'b1, 26'h40 + 26'(i), {BYTES{1'b1}}, rand_line(), 8'h0);
    for (int i = 0; i < 8; i++) req(1'b0, 26'h40 + 26'(i), '0, '0, 8'(i));
    chk("full_ready_low", mem_req_ready, 0);
    for (int i = 0; i < 10; i++) step();
    chk("full_ready_still_low", mem_req_ready, 0);
    get_rsp("t3_first");
    chk("ready_after_first_pop", mem_req_ready, 1);
    for (int i = 1; i < 8; i++) get_rsp("t3_order");

    // Address aliasing modulo MEM_DEPTH.
    req(1'b0, 26'h10, '0, '0, 8'h9);
    req(1'b0, 26'h10 + 26'(DEPTH), '0, '0, 8'hA);
    wait_valid("t4_valid_pre");
    d1 = mem_rsp_data;
    get_rsp("t4_a");
    wait_valid("t4_valid_pre2");
    chk("t4_alias_equal", mem_rsp_data, d1);
    get_rsp("t4_b");

    // Reset with reads in flight discards them.
    for (int i = 0; i < 3; i++) req(1'b0, 26'h40 + 26'(i), '0, '0, 8'(20 + i));
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk("t5_pending_zero", dut.pending_q, 0);
    exp_data_q.delete(); exp_tag_q.delete();
    mem_rsp_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (mem_rsp_valid) seen++;
      step();
    end
    mem_rsp_ready = 1'b0;
    chk("t5_no_rsp_after_reset", seen, 0);
    req(1'b0, 26'h10, '0, '0, 8'h33);
    get_rsp("t5_new_read");

    // Randomized traffic against the model.
    for (int i = 0; i < 16; i++) req(1'b1, 26'(i), {BYTES{1'b1}}, rand_line(), 8'h0);
    ops = 0; cyc = 0; prev_hold = 1'b0; prev_data = '0; prev_tag = '0;
    while (ops < 1000 && cyc < 30000) begin
      if (!mem_req_valid && $urandom_range(0, 3) != 0) begin
        mem_req_valid = 1'b1;
        mem_req_rw = 1'($urandom_range(0, 1));
        mem_req_addr = 26'($urandom_range(0, 63) * DEPTH + $urandom_range(0, 15));
        mem_req_byteen = {$urandom(), $urandom()};
        mem_req_data = rand_line();
        mem_req_tag = 8'($urandom_range(0, 255));
      end
      mem_rsp_ready = ($urandom_range(0, 2) != 0);
      if (prev_hold) begin
        chk("rnd_hold_data", mem_rsp_data, prev_data);
        chk("rnd_hold_tag", mem_rsp_tag, prev_tag);
      end
      if (mem_rsp_valid && mem_rsp_ready) begin
        if (exp_data_q.size() == 0) begin
          chk("rnd_unexpected", mem_rsp_valid, 0);
        end else begin
          chk("rnd_data", mem_rsp_data, exp_data_q.pop_front());
          chk("rnd_tag", mem_rsp_tag, exp_tag_q.pop_front());
        end
      end
      prev_hold = mem_rsp_valid && !mem_rsp_ready;
      prev_data = mem_rsp_data;
      prev_tag  = mem_rsp_tag;
      fired = mem_req_valid && mem_req_ready;
      if (fired) begin
        model_fire(mem_req_rw, mem_req_addr, mem_req_byteen, mem_req_data, mem_req_tag);
        ops++;
      end
      step();
      cyc++;
      if (fired) mem_req_valid = 1'b0;
    end
    chk("rnd_ops_done", ops, 1000);

    mem_req_valid = 1'b0;
    mem_rsp_ready = 1'b1;
    for (int i = 0; i < 400 && exp_data_q.size() != 0; i++) begin
      if (mem_rsp_valid) begin
        chk("drain_data", mem_rsp_data, exp_data_q.pop_front());
        chk("drain_tag", mem_rsp_tag, exp_tag_q.pop_front());
      end
      step();
    end
    chk("drain_empty", exp_data_q.size(), 0);
    chk("drain_rsp_valid_low", mem_rsp_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vx_mem_responder.md
# vx_mem_responder

Memory-side responder for the Vortex memory request/response interface. It accepts the processor's `mem_req_*` traffic, services it from on-chip storage with byte-enabled writes, and returns read data with the original tag on `mem_rsp_*`. It serves as the memory endpoint for simulation and FPGA smoke builds. It also exercises the processor's backpressure and tag handling through a fixed-latency pipeline and a bounded response queue.

## Interface
- `DATA_WIDTH`, 512: bits per memory line.
- `ADDR_WIDTH`, 26: line-address width.
- `TAG_WIDTH`, 8: request tag width, returned unchanged.
- `MEM_DEPTH`, 1024: storage lines; power of two, ≥2.
- `LATENCY`, 4: read pipeline depth in cycles; ≥1.
- `QUEUE_SIZE`, 8: response FIFO entries and maximum outstanding reads; power of two, ≥2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `mem_req_valid`  in  1  request valid.
- `mem_req_rw`  in  1  1 = write, 0 = read.
- `mem_req_byteen`  in  DATA_WIDTH/8  write byte enables.
- `mem_req_addr`  in  ADDR_WIDTH  line address.
- `mem_req_data`  in  DATA_WIDTH  write data.
- `mem_req_tag`  in  TAG_WIDTH  request tag.
- `mem_req_ready`  out  1  request accepted when valid && ready.
- `mem_rsp_valid`  out  1  response valid.
- `mem_rsp_data`  out  DATA_WIDTH  read data.
- `mem_rsp_tag`  out  TAG_WIDTH  tag of the originating read.
- `mem_rsp_ready`  in  1  response consumed when valid && ready.

## Operation
- Storage index = `mem_req_addr[log2(MEM_DEPTH)-1:0]`. Upper address bits are ignored, so addresses alias modulo MEM_DEPTH.
- Write fire: each byte b with `byteen[b]=1` is updated at the fire edge. No response is generated, and writes do not consume credit.
- Read fire: the line is read at the fire edge and enters a LATENCY-stage shift pipeline carrying {valid, data, tag}. On exit it is pushed into the response FIFO.
- Ordering: responses return in request order. A read accepted in the cycle after a write to the same index returns the new data.
- Credit counter `pending` (width log2(QUEUE_SIZE)+1):
  - +1 on read fire, −1 on response fire, unchanged when both occur in the same cycle.
  - Counts reads in the pipeline plus reads in the FIFO.
- `mem_req_ready` = !reset && (pending < QUEUE_SIZE), for both reads and writes. It is combinational from registered state and never depends on `mem_req_valid`.
- The FIFO can never overflow, because credit bounds pipeline + FIFO to QUEUE_SIZE. An overflow push or an underflow pop is an assertion failure.
- Response head:
  - `mem_rsp_valid` = FIFO non-empty.
  - data and tag come from the FIFO head and are held stable while valid && !ready.
  - A pop and a push in the same cycle are both honoured; count is unchanged.
  - The FIFO pointers wrap modulo QUEUE_SIZE.
- Reset mid-operation discards all pipeline and FIFO contents and clears `pending`. Storage contents are not reset.

## Timing
- Values while `reset` is high and in the first cycle after it:
  - `mem_rsp_valid`=0, `mem_rsp_data`=0, `mem_rsp_tag`=0.
  - `mem_req_ready`=0 during reset and 1 in the first cycle after reset deasserts.
- Read latency: a read fired at edge T gives `mem_rsp_valid`=1 in the cycle following edge T+LATENCY, provided the FIFO is empty. This is LATENCY+1 cycles, including the FIFO write.
- Throughput: one request per cycle. Sustained reads run back-to-back while `mem_rsp_ready`=1.
- Full: when `pending` reaches QUEUE_SIZE, `mem_req_ready` drops in the next cycle. It rises in the cycle after the first response fire.
- Stall: while `mem_rsp_ready`=0, pipeline entries keep draining into the FIFO, which cannot overflow because of the credit bound.

## Configuration
- `VX_MEM_RSP_RANDOM_STALL_EN` defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1, loaded on reset) advances every cycle.
  - `mem_req_ready` is additionally forced to 0 when `lfsr[1:0]==2'b00`.
  - `mem_rsp_valid` is gated the same way using `lfsr[3:2]==2'b00`; head data stays stable.
- Not defined: no LFSR; ready and valid behave exactly as described above.

## Test plan
- Reset, then write 0xA5 to all bytes at address 0x10 and read 0x10 with tag 0x3 -> response data all 0xA5, tag 0x3, valid exactly LATENCY+1 cycles after the read fire.
- Write with byteen=1 only on byte 0 (value 0x11) over the prior 0xA5 line, then read -> byte 0 = 0x11, all other bytes 0xA5.
- Issue 8 reads with tags 0..7 while `mem_rsp_ready`=0 -> `mem_req_ready`=0 after the 8th fire. Then hold ready=1 -> tags 0..7 return in order and `mem_req_ready` returns to 1 after the first pop.
- Reads to address 0x10 and 0x10+MEM_DEPTH -> identical data (aliasing).
- Assert `reset` for 1 cycle with 3 reads in flight -> no responses afterward and `pending`=0. A new read completes normally.
- With the macro defined, run 1000 random reads/writes against a scoreboard -> all data and tags match, and the valid/data stability rule holds under stall.
